uart_rx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_rx_fifo_if.sv | 26 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/uart_rx_fifo.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types, parity encodings and parameter-legality helpers for the UART blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  function automatic bit clks_per_bit_ok(int unsigned n);
    return n >= 4;
  endfunction

  function automatic bit data_bits_ok(int unsigned n);
    return (n >= 5) && (n <= 8);
  endfunction

  function automatic bit parity_ok(int unsigned p);
    return p <= PARITY_EVEN;
  endfunction

  function automatic bit stop_bits_ok(int unsigned n);
    return (n == 1) || (n == 2);
  endfunction

  function automatic bit fifo_depth_ok(int unsigned d);
    return (d >= 2) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Consumer-side register interface of the UART receiver: FIFO head, pop, level and sticky errors.
interface uart_rx_fifo_if #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;

  logic                 re;
  logic                 clr_err;
  logic [DATA_BITS-1:0] dout;
  logic                 empty;
  logic [LevelW-1:0]    level;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    output re, clr_err,
    input  dout, empty, level, frame_err, parity_err, overrun
  );

  modport slave (
    input  re, clr_err,
    output dout, empty, level, frame_err, parity_err, overrun
  );
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered empty/level; push succeeds when full
// if a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q, level_q, level_d;
  logic             empty_q;
  logic             do_push, do_pop;

  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop && !empty_q;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + (AW+1)'(1);
    end else if (!do_push && do_pop) begin
      level_d = level_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
      level_q <= level_d;
      empty_q <= (level_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rptr_q[AW-1:0]];
  assign empty = empty_q;
  assign level = level_q;
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format, 2-flop input synchroniser, FWFT receive FIFO
// and sticky frame/parity/overrun flags. Never stalls: frames arriving into a full FIFO are dropped.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1000,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  uart_rx_fifo_if.slave bus
);
  localparam int unsigned CntW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned HalfCnt = (CLKS_PER_BIT - 1) / 2;

  if (!clks_per_bit_ok(CLKS_PER_BIT)) begin : gen_bad_cpb
    $error("CLKS_PER_BIT must be at least 4");
  end
  if (!data_bits_ok(DATA_BITS)) begin : gen_bad_data
    $error("DATA_BITS must be 5..8");
  end
  if (!parity_ok(PARITY)) begin : gen_bad_parity
    $error("PARITY must be 0, 1 or 2");
  end
  if (!stop_bits_ok(STOP_BITS)) begin : gen_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (!fifo_depth_ok(FIFO_DEPTH)) begin : gen_bad_depth
    $error("FIFO_DEPTH must be a power of 2, at least 2");
  end

  logic                 rx_m_q, rx_s_q;
  rx_state_t            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 frm_bad_q, frm_bad_d;
  logic                 frame_err_q, parity_err_q, overrun_q;
  logic                 sample, commit, frame_bad, good;
  logic                 set_frame, set_par, set_ovr, push, fifo_full;

  assign sample = (cnt_q == CntW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CntW'(1);
    bit_d     = bit_q;
    stop_d    = stop_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    frm_bad_d = frm_bad_q;
    commit    = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d     = '0;
        bit_d     = '0;
        stop_d    = 1'b0;
        par_bad_d = 1'b0;
        frm_bad_d = 1'b0;
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == CntW'(HalfCnt)) begin
          cnt_d   = '0;
          state_d = rx_s_q ? StIdle : StData;
        end
      end
      StData: begin
        if (sample) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == 3'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? StParity : StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (sample) begin
          cnt_d     = '0;
          par_bad_d = ((^shift_q) ^ rx_s_q) != (PARITY == PARITY_ODD);
          state_d   = StStop;
        end
      end
      StStop: begin
        if (sample) begin
          cnt_d = '0;
          if (!rx_s_q) frm_bad_d = 1'b1;
          // Leave at mid-stop-bit so the next start edge is not missed.
          if (stop_q == 1'(STOP_BITS - 1)) begin
            commit  = 1'b1;
            state_d = StIdle;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign frame_bad = frm_bad_q || !rx_s_q;
  assign set_frame = commit && frame_bad;
  assign set_par   = commit && par_bad_q;
  assign good      = commit && !frame_bad && !par_bad_q;
  assign set_ovr   = good && fifo_full && !bus.re;
  assign push      = good && !set_ovr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m_q       <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_q        <= '0;
      stop_q       <= 1'b0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      frm_bad_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_m_q       <= rx;
      rx_s_q       <= rx_m_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      stop_q       <= stop_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      frm_bad_q    <= frm_bad_d;
      frame_err_q  <= set_frame || (frame_err_q && !bus.clr_err);
      parity_err_q <= set_par || (parity_err_q && !bus.clr_err);
      overrun_q    <= set_ovr || (overrun_q && !bus.clr_err);
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (shift_q),
    .pop   (bus.re),
    .rdata (bus.dout),
    .empty (bus.empty),
    .full  (fifo_full),
    .level (bus.level)
  );

  assign bus.frame_err  = frame_err_q;
  assign bus.parity_err = parity_err_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised and directed bench for uart_rx_fifo: an 8N1 and a 7E2 instance against a
// queue-based model of the receive FIFO and sticky flags.
module tb_uart_rx_fifo;
  localparam int CPB  = 16;
  localparam int HALF = (CPB - 1) / 2;
  localparam int DEP  = 4;

  logic clk = 1'b0;
  logic rst, rx_a, rx_b;

  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(DEP)) bus_a ();
  uart_rx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(DEP)) bus_b ();

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB), .DATA_BITS (8), .PARITY (0), .STOP_BITS (1), .FIFO_DEPTH (DEP)
  ) u_dut_a (
    .clk (clk), .rst (rst), .rx (rx_a), .bus (bus_a)
  );

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB), .DATA_BITS (7), .PARITY (2), .STOP_BITS (2), .FIFO_DEPTH (DEP)
  ) u_dut_b (
    .clk (clk), .rst (rst), .rx (rx_b), .bus (bus_b)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Model of instance A: FIFO contents and sticky flags.
  logic [7:0] q_a[$];
  bit m_frame, m_par, m_ovr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame; optionally raises re for the commit cycle and reports level/empty
  // just before and just after the commit edge.
  task automatic send_frame(input bit to_b, input logic [7:0] data, input bit bad_stop,
                            input bit flip_par, input bit re_on_commit,
                            output logic [2:0] lvl_pre, output logic [2:0] lvl_post,
                            output logic emp_pre, output logic emp_post);
    int nd, ns, nb, last, commit;
    logic [15:0] fb;
    logic p;
    nd = to_b ? 7 : 8;
    ns = to_b ? 2 : 1;
    fb = '1;
    fb[0] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < nd; i++) begin
      fb[1+i] = data[i];
      p ^= data[i];
    end
    nb = 1 + nd;
    if (to_b) begin
      fb[nb] = p ^ flip_par;  // even parity: total ones even
      nb++;
    end
    for (int i = 0; i < ns; i++) begin
      fb[nb] = ~bad_stop;
      nb++;
    end
    last   = nb - 2;
    commit = 4 + HALF + CPB * (last + 1);
    lvl_pre = 'x; lvl_post = 'x; emp_pre = 1'bx; emp_post = 1'bx;
    tick();
    if (to_b) rx_b = fb[0]; else rx_a = fb[0];
    for (int k = 1; k < nb * CPB; k++) begin
      tick();
      if (k % CPB == 0) begin
        if (to_b) rx_b = fb[k / CPB]; else rx_a = fb[k / CPB];
      end
      if (k == commit - 1) begin
        lvl_pre = to_b ? bus_b.level : bus_a.level;
        emp_pre = to_b ? bus_b.empty : bus_a.empty;
        if (re_on_commit) begin
          if (to_b) bus_b.re = 1'b1; else bus_a.re = 1'b1;
        end
      end
      if (k == commit) begin
        lvl_post = to_b ? bus_b.level : bus_a.level;
        emp_post = to_b ? bus_b.empty : bus_a.empty;
        bus_a.re = 1'b0;
        bus_b.re = 1'b0;
      end
    end
    tick();
    if (to_b) rx_b = 1'b1; else rx_a = 1'b1;
    repeat (4) tick();
  endtask

  function automatic void model_frame(input logic [7:0] data, input bit bad_stop, input bit re);
    if (re && q_a.size() > 0) void'(q_a.pop_front());
    if (bad_stop) m_frame = 1'b1;
    else if (q_a.size() == DEP) m_ovr = 1'b1;
    else q_a.push_back(data);
  endfunction

  task automatic frame_a(input logic [7:0] data, input bit bad_stop, input bit re);
    logic [2:0] lp, lq;
    logic ep, eq;
    send_frame(1'b0, data, bad_stop, 1'b0, re, lp, lq, ep, eq);
    model_frame(data, bad_stop, re);
  endtask

  task automatic state_a(input string tag);
    check({tag, ".empty"}, 32'(bus_a.empty), 32'(q_a.size() == 0));
    check({tag, ".level"}, 32'(bus_a.level), 32'(q_a.size()));
    check({tag, ".frame_err"}, 32'(bus_a.frame_err), 32'(m_frame));
    check({tag, ".parity_err"}, 32'(bus_a.parity_err), 32'(m_par));
    check({tag, ".overrun"}, 32'(bus_a.overrun), 32'(m_ovr));
    if (q_a.size() > 0) check({tag, ".dout"}, 32'(bus_a.dout), 32'(q_a[0]));
  endtask

  task automatic pop_a(input string tag);
    check({tag, ".empty"}, 32'(bus_a.empty), 32'(q_a.size() == 0));
    if (q_a.size() > 0) begin
      check({tag, ".dout"}, 32'(bus_a.dout), 32'(q_a[0]));
      void'(q_a.pop_front());
    end
    bus_a.re = 1'b1;
    tick();
    bus_a.re = 1'b0;
  endtask

  task automatic clr_a();
    bus_a.clr_err = 1'b1;
    tick();
    bus_a.clr_err = 1'b0;
    m_frame = 1'b0; m_par = 1'b0; m_ovr = 1'b0;
  endtask

  initial begin
    logic [2:0] lp, lq;
    logic ep, eq;
    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    bus_a.re = 1'b0; bus_a.clr_err = 1'b0;
    bus_b.re = 1'b0; bus_b.clr_err = 1'b0;
    m_frame = 1'b0; m_par = 1'b0; m_ovr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    state_a("reset");
    check("reset.b_empty", 32'(bus_b.empty), 32'd1);

    // 8N1 0xA5: visible exactly one cycle after the final stop sample.
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, lp, lq, ep, eq);
    model_frame(8'hA5, 1'b0, 1'b0);
    check("a5.empty_before", 32'(ep), 32'd1);
    check("a5.empty_after", 32'(eq), 32'd0);
    check("a5.level_after", 32'(lq), 32'd1);
    state_a("a5");
    pop_a("a5.pop");
    state_a("a5.drained");

    // 7E2: good parity, then flipped parity.
    send_frame(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, lp, lq, ep, eq);
    send_frame(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, lp, lq, ep, eq);
    check("7e2.level", 32'(bus_b.level), 32'd1);
    check("7e2.dout", 32'(bus_b.dout), 32'h3C);
    check("7e2.parity_err", 32'(bus_b.parity_err), 32'd1);
    check("7e2.frame_err", 32'(bus_b.frame_err), 32'd0);

    // Framing error, clear, then normal reception.
    frame_a(8'h55, 1'b1, 1'b0);
    state_a("ferr");
    clr_a();
    state_a("ferr.clr");
    frame_a(8'h12, 1'b0, 1'b0);
    state_a("after_ferr");
    pop_a("after_ferr.pop");

    // Overrun with no consumer.
    for (int i = 1; i <= 5; i++) frame_a(8'(i), 1'b0, 1'b0);
    state_a("ovr");
    for (int i = 0; i < 5; i++) pop_a("ovr.pop");
    clr_a();
    state_a("ovr.drained");

    // Full FIFO with re on the commit cycle: push and pop both take effect.
    for (int i = 1; i <= 4; i++) frame_a(8'(i), 1'b0, 1'b0);
    send_frame(1'b0, 8'h05, 1'b0, 1'b0, 1'b1, lp, lq, ep, eq);
    model_frame(8'h05, 1'b0, 1'b1);
    check("full_re.level_pre", 32'(lp), 32'd4);
    check("full_re.level_post", 32'(lq), 32'd4);
    state_a("full_re");
    for (int i = 0; i < 4; i++) pop_a("full_re.pop");
    state_a("full_re.drained");

    // Short glitch is rejected silently.
    tick();
    rx_a = 1'b0;
    repeat (3) tick();
    rx_a = 1'b1;
    repeat (3 * CPB) tick();
    state_a("glitch");
    frame_a(8'hC3, 1'b0, 1'b0);
    state_a("glitch.after");

    // Randomised traffic.
    for (int n = 0; n < 24; n++) begin
      int pops;
      frame_a(8'($urandom), ($urandom % 8) == 0, ($urandom % 6) == 0);
      state_a("rand");
      pops = $urandom % 3;
      for (int j = 0; j < pops; j++) pop_a("rand.pop");
      if (($urandom % 5) == 0) clr_a();
    end

    // Reset in the middle of a frame's data bits.
    if (q_a.size() == 0) frame_a(8'h77, 1'b0, 1'b0);
    tick();
    rx_a = 1'b0;
    repeat (CPB * 3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q_a.delete();
    m_frame = 1'b0; m_par = 1'b0; m_ovr = 1'b0;
    state_a("mid_rst");
    rx_a = 1'b1;
    repeat (3 * CPB) tick();
    state_a("mid_rst.idle");
    frame_a(8'h9E, 1'b0, 1'b0);
    state_a("mid_rst.after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
